// File: rtl/ex_mul_sequencer.sv
// ---------------------------------------------------------------------------
// ex_mul_sequencer
//
// Purpose:
//   Sequences a multi-cycle iterative multiply in the EX stage of an in-order
//   pipeline. The sequencer detects a mul (ALUCtl == 3) in EX and starts the
//   multiplier. It holds the front of the pipeline (Stall) for MUL_LAT-1
//   cycles. It then lets EX/MEM capture the result in the final cycle.
//   A redirect (Flush) cancels an in-flight mul and pulses MulAbort.
//
// Parameters:
//   MUL_LAT     total EX-stage occupancy of a mul in cycles (2..15)
//
// Ports:
//   Clk         clock; all state updates on its rising edge
//   Reset       synchronous active-high reset
//   ExValid     EX stage holds a valid instruction
//   ALUCtl[5:0] ALU control code of the EX instruction (3 = mul)
//   Flush       redirect kills the EX instruction this cycle
//   Stall       freezes PC, IF/ID and ID/EX
//   MulStart    one-cycle pulse that starts the multiplier
//   MulAbort    one-cycle pulse that cancels the multiplier
//   MulBusy     high while a mul is in flight after its start cycle
//   ExMemWrEn   EX/MEM capture enable (0 inserts a bubble)
//   StallCount  saturating count of stall cycles
//               (only present when EX_PERF_CNT_EN is defined)
//
// Build options:
//   EX_PERF_CNT_EN  adds the StallCount port and its counter
// ---------------------------------------------------------------------------
module ex_mul_sequencer #(
    parameter int MUL_LAT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ExValid,
    input  logic [5:0]  ALUCtl,
    input  logic        Flush,
    output logic        Stall,
    output logic        MulStart,
    output logic        MulAbort,
    output logic        MulBusy,
    output logic        ExMemWrEn
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0] StallCount
`endif
);

    localparam logic [5:0] ALU_MUL = 6'd3;

    // The detect cycle and the DONE cycle account for two of the MUL_LAT
    // cycles. BUSY therefore lasts CNT_INIT+1 cycles.
    localparam logic [3:0] CNT_INIT = (MUL_LAT > 2) ? 4'(MUL_LAT - 3) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic       mul_detect;

    assign mul_detect = ExValid && (ALUCtl == ALU_MUL) && !Flush;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        Stall      = 1'b0;
        MulStart   = 1'b0;
        MulAbort   = 1'b0;
        MulBusy    = 1'b0;
        ExMemWrEn  = 1'b0;

        // While Reset is high every output is held at 0. The multiplier
        // shares the same reset, so no abort pulse is needed.
        if (!Reset) begin
            unique case (state_reg)
                IDLE: begin
                    if (mul_detect) begin
                        Stall    = 1'b1;
                        MulStart = 1'b1;
                        if (MUL_LAT > 2) begin
                            cnt_next   = CNT_INIT;
                            state_next = BUSY;
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        ExMemWrEn = 1'b1;
                    end
                end

                BUSY: begin
                    MulBusy = 1'b1;
                    // A flush wins over counter expiry. The stall is
                    // released so that the redirect can proceed.
                    if (Flush) begin
                        MulAbort   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        Stall = 1'b1;
                        if (cnt_reg == 4'd0) begin
                            state_next = DONE;
                        end else begin
                            cnt_next = cnt_reg - 4'd1;
                        end
                    end
                end

                DONE: begin
                    // ALUCtl still shows the completing mul here. It is
                    // therefore not re-examined until the next IDLE cycle.
                    MulBusy    = 1'b1;
                    state_next = IDLE;
                    if (Flush) begin
                        MulAbort = 1'b1;
                    end else begin
                        ExMemWrEn = 1'b1;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef EX_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Stall is already forced low during reset. The reset branch still
    // clears the counter explicitly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_reg <= 32'd0;
        end else if (Stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign StallCount = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ex_mul_sequencer
//
// Directed bench for ex_mul_sequencer.
//   - One instance uses the default MUL_LAT of 4.
//   - One instance uses the MUL_LAT=2 boundary.
// Each cycle drives one instance and compares the packed output vector
// {Stall, MulStart, MulAbort, MulBusy, ExMemWrEn} against a hand-derived
// value. The output vector is sampled on the falling edge. The stall
// counter checks are built only when EX_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ex_mul_sequencer;

    logic       clk;
    logic       rst4, ev4, fl4;
    logic [5:0] alu4;
    logic       stall4, start4, abort4, busy4, wr4;
    logic       rst2, ev2, fl2;
    logic [5:0] alu2;
    logic       stall2, start2, abort2, busy2, wr2;
`ifdef EX_PERF_CNT_EN
    logic [31:0] scnt4, scnt2;
`endif

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ex_mul_sequencer #(.MUL_LAT(4)) dut4 (
        .Clk(clk), .Reset(rst4), .ExValid(ev4), .ALUCtl(alu4), .Flush(fl4),
        .Stall(stall4), .MulStart(start4), .MulAbort(abort4),
        .MulBusy(busy4), .ExMemWrEn(wr4)
`ifdef EX_PERF_CNT_EN
        , .StallCount(scnt4)
`endif
    );

    ex_mul_sequencer #(.MUL_LAT(2)) dut2 (
        .Clk(clk), .Reset(rst2), .ExValid(ev2), .ALUCtl(alu2), .Flush(fl2),
        .Stall(stall2), .MulStart(start2), .MulAbort(abort2),
        .MulBusy(busy2), .ExMemWrEn(wr2)
`ifdef EX_PERF_CNT_EN
        , .StallCount(scnt2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // One cycle: drive the selected instance and hold the other one idle.
    // exp = {Stall, MulStart, MulAbort, MulBusy, ExMemWrEn}
    task automatic cyc(input string tag, input bit sel2, input logic rst, input logic ev,
                       input logic [5:0] alu, input logic fl, input logic [4:0] exp);
        logic [4:0] obs;
        if (sel2) begin
            rst2 = rst; ev2 = ev; alu2 = alu; fl2 = fl;
            rst4 = 1'b0; ev4 = 1'b0; alu4 = 6'd0; fl4 = 1'b0;
        end else begin
            rst4 = rst; ev4 = ev; alu4 = alu; fl4 = fl;
            rst2 = 1'b0; ev2 = 1'b0; alu2 = 6'd0; fl2 = 1'b0;
        end
        @(negedge clk);
        obs = sel2 ? {stall2, start2, abort2, busy2, wr2}
                   : {stall4, start4, abort4, busy4, wr4};
        chk(tag, {27'd0, obs}, {27'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] nonmul [4];
        nonmul[0] = 6'd0; nonmul[1] = 6'd2; nonmul[2] = 6'd19; nonmul[3] = 6'd28;

        // Reset both instances with a mul presented. All outputs must stay low.
        rst4 = 1'b1; ev4 = 1'b1; alu4 = 6'd3; fl4 = 1'b0;
        rst2 = 1'b1; ev2 = 1'b1; alu2 = 6'd3; fl2 = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset4_%0d", i), {27'd0, stall4, start4, abort4, busy4, wr4}, 32'd0);
            chk($sformatf("reset2_%0d", i), {27'd0, stall2, start2, abort2, busy2, wr2}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Non-mul stream: pass-through every cycle.
        for (int i = 0; i < 4; i++)
            cyc($sformatf("nonmul_%0d", nonmul[i]), 1'b0, 1'b0, 1'b1, nonmul[i], 1'b0, 5'b00001);
        cyc("invalid_mulcode", 1'b0, 1'b0, 1'b0, 6'd3, 1'b0, 5'b00001);

        // Single mul, MUL_LAT=4. ExValid drops mid-BUSY and must be ignored.
        cyc("m4_start",    1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
        cyc("m4_busy1",    1'b0, 1'b0, 1'b0, 6'd3, 1'b0, 5'b10010);
        cyc("m4_busy2",    1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
        cyc("m4_done",     1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b00011);
        cyc("m4_idle",     1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 5'b00001);

        // Back-to-back muls with no gap.
        for (int k = 0; k < 2; k++) begin
            cyc($sformatf("b2b%0d_start", k), 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
            cyc($sformatf("b2b%0d_busy1", k), 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
            cyc($sformatf("b2b%0d_busy2", k), 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
            cyc($sformatf("b2b%0d_done", k),  1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b00011);
        end
        cyc("b2b_idle", 1'b0, 1'b0, 1'b1, 6'd28, 1'b0, 5'b00001);

        // Flush in IDLE suppresses start and stall.
        cyc("flush_idle", 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 5'b00001);

        // Flush in the first BUSY cycle.
        cyc("fb1_start", 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
        cyc("fb1_flush", 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 5'b00110);
        cyc("fb1_idle",  1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 5'b00001);

        // Flush with Cnt=0 wins over expiry.
        cyc("fb2_start", 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
        cyc("fb2_busy",  1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
        cyc("fb2_flush", 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 5'b00110);
        cyc("fb2_idle",  1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 5'b00001);

        // Flush in DONE blocks the result capture.
        cyc("fd_start", 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
        cyc("fd_busy1", 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
        cyc("fd_busy2", 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
        cyc("fd_flush", 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 5'b00110);
        cyc("fd_idle",  1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 5'b00001);

        // Reset mid-mul: no abort pulse, then a fresh mul runs normally.
        cyc("rm_start",  1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
        cyc("rm_reset",  1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 5'b00000);
        cyc("rm_start2", 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
        cyc("rm_busy1",  1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
        cyc("rm_busy2",  1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b10010);
        cyc("rm_done",   1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 5'b00011);

        // MUL_LAT=2 boundary: detect goes straight to DONE, and back-to-back works.
        for (int k = 0; k < 2; k++) begin
            cyc($sformatf("m2_%0d_start", k), 1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
            cyc($sformatf("m2_%0d_done", k),  1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 5'b00011);
        end
        cyc("m2_fstart", 1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
        cyc("m2_fdone",  1'b1, 1'b0, 1'b1, 6'd3, 1'b1, 5'b00110);
        cyc("m2_idle",   1'b1, 1'b0, 1'b1, 6'd19, 1'b0, 5'b00001);

`ifdef EX_PERF_CNT_EN
        // MUL_LAT=2 instance: reset, then three muls give 3 stall cycles.
        cyc("pc_reset", 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 5'b00000);
        chk("pc_cleared", scnt2, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("pc%0d_start", k), 1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
            cyc($sformatf("pc%0d_done", k),  1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 5'b00011);
        end
        chk("pc_three", scnt2, 32'd3);
        // Saturation: preload the counter one below the maximum, then stall twice.
        force dut2.stall_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut2.stall_cnt_reg;
        for (int k = 0; k < 2; k++) begin
            cyc($sformatf("ps%0d_start", k), 1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 5'b11000);
            cyc($sformatf("ps%0d_done", k),  1'b1, 1'b0, 1'b1, 6'd3, 1'b0, 5'b00011);
        end
        chk("pc_saturate", scnt2, 32'hFFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so that the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ex_mul_sequencer.md
EX_MUL_SEQUENCER -- requirements
Module: ex_mul_sequencer

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, meaning the total EX-stage occupancy in cycles of a mul instruction; legal range 2..15.
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port ExValid, input, 1 bit, meaning the EX stage holds a valid instruction.
REQ-005 SHALL have port ALUCtl, input, 6 bits, the ALU control code of the EX instruction; code 3 = mul, all other codes single-cycle.
REQ-006 SHALL have port Flush, input, 1 bit, meaning a redirect kills the EX instruction this cycle.
REQ-007 SHALL have port Stall, output, 1 bit, which freezes the PC, IF/ID and ID/EX registers.
REQ-008 SHALL have port MulStart, output, 1 bit, a one-cycle pulse that starts the iterative multiplier.
REQ-009 SHALL have port MulAbort, output, 1 bit, a one-cycle pulse that cancels the multiplier.
REQ-010 SHALL have port MulBusy, output, 1 bit, high while a mul is in flight after its start cycle.
REQ-011 SHALL have port ExMemWrEn, output, 1 bit, which enables EX/MEM register capture; 0 inserts a bubble.
REQ-012 SHALL have port StallCount, output, 32 bits, present only when EX_PERF_CNT_EN is defined.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE with a 4-bit down-counter Cnt.
REQ-014 In IDLE with ExValid=1, ALUCtl=3 and Flush=0 (mul detect), SHALL drive Stall=1, MulStart=1 and ExMemWrEn=0 in that cycle, combinationally from the inputs.
REQ-015 On mul detect with MUL_LAT>2, SHALL load Cnt=MUL_LAT-3 and enter BUSY.
REQ-016 On mul detect with MUL_LAT=2, SHALL enter DONE directly.
REQ-017 In IDLE without mul detect, SHALL drive Stall=0, MulStart=0, MulAbort=0 and ExMemWrEn=1, and SHALL remain in IDLE.
REQ-018 In BUSY, SHALL drive Stall=1, MulBusy=1 and ExMemWrEn=0.
REQ-019 In BUSY, SHALL decrement Cnt while Cnt is nonzero and SHALL enter DONE when Cnt=0.
REQ-020 In DONE, SHALL drive Stall=0, MulBusy=1 and ExMemWrEn=1 so that the mul result is captured, and SHALL return to IDLE.
REQ-021 In DONE, SHALL ignore ALUCtl, since it still shows the completing mul.
REQ-022 Total Stall-high cycles per mul SHALL be exactly MUL_LAT-1; the instruction occupies EX for exactly MUL_LAT cycles.
REQ-023 Back-to-back muls SHALL be handled with no gap: the cycle after DONE re-evaluates mul detect in IDLE.
REQ-024 Flush in IDLE SHALL suppress MulStart and Stall.
REQ-025 Flush in BUSY or DONE SHALL, in that same cycle, drive Stall=0, ExMemWrEn=0 and MulAbort=1.
REQ-026 Flush in BUSY or DONE SHALL cause the next state to be IDLE.
REQ-027 Flush SHALL take priority over counter expiry and over DONE completion.
REQ-028 ExValid dropping during BUSY or DONE SHALL be ignored; only Flush cancels an in-flight mul.
REQ-029 MulStart and MulAbort SHALL never both be high in the same cycle.
REQ-030 MulBusy SHALL be low in IDLE.

Reset
REQ-031 While Reset=1, SHALL drive Stall=0, MulStart=0, MulAbort=0, MulBusy=0 and ExMemWrEn=0.
REQ-032 On the clock edge with Reset=1, SHALL set state to IDLE and Cnt to 0, and SHALL clear StallCount when it is present.
REQ-033 Reset mid-operation (in BUSY or DONE) SHALL abandon the mul without pulsing MulAbort; the multiplier is reset by the same signal.
REQ-034 Reset SHALL take priority over Flush and over all other inputs.

Configuration
REQ-035 With macro EX_PERF_CNT_EN defined, SHALL provide StallCount, which increments by 1 on each clock edge where Stall=1 and Reset=0.
REQ-036 StallCount SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-037 With EX_PERF_CNT_EN undefined, the StallCount port and counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Scenario: MUL_LAT=4, single mul (ExValid=1, ALUCtl=3) at cycle 10 -> MulStart=1 at cycle 10; Stall=1 at cycles 10-12; ExMemWrEn=1 at cycle 13; MulBusy=1 at cycles 11-13.
REQ-039 Scenario: MUL_LAT=4, two consecutive muls at cycles 10 and 14 -> MulStart pulses at cycles 10 and 14; Stall=1 at cycles 10-12 and 14-16; Stall=0 at cycle 13.
REQ-040 Scenario: MUL_LAT=4, mul at cycle 10 and Flush=1 at cycle 11 -> MulAbort=1 and Stall=0 at cycle 11; state IDLE at cycle 12; no ExMemWrEn=1 for the mul.
REQ-041 Scenario: non-mul stream (ALUCtl=0, 2, 19, 28) -> Stall=0 and ExMemWrEn=1 every cycle; MulStart is never asserted.
REQ-042 Scenario: mul at cycle 10 and Reset=1 at cycle 11 -> all outputs 0 at cycle 11; IDLE at cycle 12; a mul at cycle 12 starts normally.
REQ-043 Scenario: with EX_PERF_CNT_EN defined and MUL_LAT=2, three muls -> StallCount=3; a forced count of 32'hFFFFFFFE followed by two stall cycles -> StallCount=32'hFFFFFFFF.
